// File: rtl/arm_ctrl_pkg.sv
// Shared state encodings, op codes and datapath select codes for the multicycle ARM control FSM.
package arm_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/ctrl_state_decode.sv
// Combinational decode of the control state into datapath selects and raw strobes.
module ctrl_state_decode
    import arm_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [1:0] op,
    output logic       ir_write,
    output logic       next_pc,
    output logic       branch,
    output logic       reg_w,
    output logic       mem_w,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] result_src,
    output logic       undef
);

    // Moore output table; everything not set in a state stays 0
    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = 1'b0;
        result_src = RES_ALUOUT;
        undef      = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                undef      = (op == OP_UND);
            end
            S_MEMADR:   alu_src_b = SRCB_IMM;
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                alu_src_b = SRCB_REG;
                alu_op    = 1'b1;
            end
            S_EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM control FSM: state register, sequencing, reset gating and memory-ready hold.
// Optional build macro: MEM_READY_EN adds a mem_ready input that stalls FETCH/MEMREAD/MEMWRITE.
module multicycle_ctrl_fsm
    import arm_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
`ifdef MEM_READY_EN
    input  logic               mem_ready,
`endif
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    output logic               ir_write,
    output logic               next_pc,
    output logic               branch,
    output logic               reg_w,
    output logic               mem_w,
    output logic               adr_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               alu_op,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               undef,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_dec;
    logic   mem_rdy;
    logic   ir_write_raw, next_pc_raw, branch_raw, reg_w_raw, mem_w_raw, undef_raw;
    logic   unused_funct;

`ifdef MEM_READY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // Only I (funct[5]) and S/L (funct[0]) steer sequencing
    assign unused_funct = ^funct[4:1];

    // State register with next-state sequencing; memory states wait for mem_rdy
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    if (mem_rdy) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_DP:   state_q <= funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state_q <= S_MEMADR;
                        OP_BR:   state_q <= S_BRANCH;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_rdy) state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: if (mem_rdy) state_q <= S_FETCH;
                S_EXECR:    state_q <= S_ALUWB;
                S_EXECI:    state_q <= S_ALUWB;
                S_ALUWB:    state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // While in reset the selects present FETCH values
    assign state_dec = reset ? S_FETCH : state_q;

    ctrl_state_decode u_decode (
        .state      (state_dec),
        .op         (op),
        .ir_write   (ir_write_raw),
        .next_pc    (next_pc_raw),
        .branch     (branch_raw),
        .reg_w      (reg_w_raw),
        .mem_w      (mem_w_raw),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .undef      (undef_raw)
    );

    // Strobes are suppressed during reset; fetch strobes also wait for memory
    assign ir_write = ir_write_raw & ~reset & mem_rdy;
    assign next_pc  = next_pc_raw & ~reset & mem_rdy;
    assign branch   = branch_raw & ~reset;
    assign reg_w    = reg_w_raw & ~reset;
    assign mem_w    = mem_w_raw & ~reset;
    assign undef    = undef_raw & ~reset;

    assign imm_src = op;
    assign reg_src = {op == OP_MEM, op == OP_BR};
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: instruction vector table plus hand sequences.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_ready;
    logic [1:0] op;
    logic [5:0] funct;
    logic       ir_write, next_pc, branch, reg_w, mem_w, adr_src, alu_src_a, alu_op, undef;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MEM_READY_EN
        .mem_ready  (mem_ready),
`endif
        .op         (op),
        .funct      (funct),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .branch     (branch),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .undef      (undef),
        .state      (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       ir_write;
        logic       next_pc;
        logic       branch;
        logic       reg_w;
        logic       mem_w;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       undef;
    } out_t;

    typedef struct {
        string           name;
        logic [1:0]      op;
        logic [5:0]      funct;
        int              len;
        logic [4:0][3:0] seq;
    } vec_t;

    out_t  sb[$];
    vec_t  vecs[8];
    int    checks   = 0;
    int    failures = 0;

    // Expected outputs for a given state and inputs, written from the state table
    function automatic out_t model(input logic [3:0] st, input logic [1:0] o,
                                   input logic rst, input logic rdy);
        out_t e;
        e         = '0;
        e.st      = st;
        e.imm_src = o;
        e.reg_src = {o == 2'b01, o == 2'b10};
        if (rst) begin
            e.alu_src_a  = 1'b1;
            e.alu_src_b  = 2'b10;
            e.result_src = 2'b10;
            return e;
        end
        case (st)
            4'd0: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                e.ir_write = rdy; e.next_pc = rdy;
            end
            4'd1: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                e.undef = (o == 2'b11);
            end
            4'd2: e.alu_src_b = 2'b01;
            4'd3: e.adr_src = 1'b1;
            4'd4: begin e.result_src = 2'b01; e.reg_w = 1'b1; end
            4'd5: begin e.adr_src = 1'b1; e.mem_w = 1'b1; end
            4'd6: begin e.alu_src_b = 2'b00; e.alu_op = 1'b1; end
            4'd7: begin e.alu_src_b = 2'b01; e.alu_op = 1'b1; end
            4'd8: e.reg_w = 1'b1;
            4'd9: begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.branch = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input string n, input logic [1:0] o, input logic [5:0] f,
                                input int l, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.len = l;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        return v;
    endfunction

    // Drive one cycle's inputs, queue the expectation, then compare mid-cycle
    task automatic cycle(input logic [1:0] o, input logic [5:0] f, input logic rst,
                         input logic rdy, input logic [3:0] est, input string name);
        out_t e;
        out_t a;
        @(negedge clk);
        op        = o;
        funct     = f;
        reset     = rst;
        mem_ready = rdy;
        sb.push_back(model(est, o, rst, rdy));
        #1;
        a = {state, ir_write, next_pc, branch, reg_w, mem_w, adr_src, alu_src_a,
             alu_src_b, alu_op, result_src, imm_src, reg_src, undef};
        e = sb.pop_front();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s st=%0d: got %h expected %h (st,irw,npc,br,rw,mw,adr,sa,sb,aop,res,imm,rsrc,und)",
                     name, est, a, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = 2'b00;
        funct     = 6'b000000;

        vecs[0] = mk("ldr",    2'b01, 6'b011001, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        vecs[1] = mk("str",    2'b01, 6'b011000, 4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0);
        vecs[2] = mk("add_r",  2'b00, 6'b001000, 4, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0);
        vecs[3] = mk("add_i",  2'b00, 6'b101000, 4, 4'd0, 4'd1, 4'd7, 4'd8, 4'd0);
        vecs[4] = mk("b",      2'b10, 6'b000000, 3, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0);
        vecs[5] = mk("undef",  2'b11, 6'b000000, 2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
        vecs[6] = mk("subs_r", 2'b00, 6'b000101, 4, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0);
        vecs[7] = mk("ldr_i",  2'b01, 6'b111101, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);

        cycle(2'b00, 6'b000000, 1'b1, 1'b1, 4'd0, "reset0");
        cycle(2'b00, 6'b000000, 1'b1, 1'b1, 4'd0, "reset1");

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].len; k++) begin
                cycle(vecs[i].op, vecs[i].funct, 1'b0, 1'b1, vecs[i].seq[k], vecs[i].name);
            end
        end

        // Reset landing in MEMWRITE abandons the store
        cycle(2'b01, 6'b011000, 1'b0, 1'b1, 4'd0, "rst_mid");
        cycle(2'b01, 6'b011000, 1'b0, 1'b1, 4'd1, "rst_mid");
        cycle(2'b01, 6'b011000, 1'b0, 1'b1, 4'd2, "rst_mid");
        cycle(2'b01, 6'b011000, 1'b1, 1'b1, 4'd5, "rst_mid_wr");
        cycle(2'b01, 6'b011000, 1'b1, 1'b1, 4'd0, "rst_held");
        cycle(2'b01, 6'b011000, 1'b1, 1'b1, 4'd0, "rst_held");
        cycle(2'b00, 6'b001000, 1'b0, 1'b1, 4'd0, "rst_rel");
        cycle(2'b00, 6'b001000, 1'b0, 1'b1, 4'd1, "rst_rel");
        cycle(2'b00, 6'b001000, 1'b0, 1'b1, 4'd6, "rst_rel");
        cycle(2'b00, 6'b001000, 1'b0, 1'b1, 4'd8, "rst_rel");

        // Reset in DECODE with an undefined op suppresses the undef pulse
        cycle(2'b11, 6'b000000, 1'b0, 1'b1, 4'd0, "rst_dec");
        cycle(2'b11, 6'b000000, 1'b1, 1'b1, 4'd1, "rst_dec_und");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd0, "rst_dec");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd1, "rst_dec");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd6, "rst_dec");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd8, "rst_dec");

        // op changing after DECODE must not disturb the sequence
        cycle(2'b00, 6'b001000, 1'b0, 1'b1, 4'd0, "op_late");
        cycle(2'b00, 6'b001000, 1'b0, 1'b1, 4'd1, "op_late");
        cycle(2'b01, 6'b111111, 1'b0, 1'b1, 4'd6, "op_late");
        cycle(2'b10, 6'b111111, 1'b0, 1'b1, 4'd8, "op_late");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd0, "op_late");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd1, "op_late");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd6, "op_late");
        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd8, "op_late");

`ifdef MEM_READY_EN
        // FETCH stall, then a stalled store
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd0, "mr_fetch");
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd0, "mr_fetch");
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd0, "mr_fetch");
        cycle(2'b01, 6'b000000, 1'b0, 1'b1, 4'd0, "mr_fetch_go");
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd1, "mr_str");
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd2, "mr_str");
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd5, "mr_str_hold");
        cycle(2'b01, 6'b000000, 1'b0, 1'b0, 4'd5, "mr_str_hold");
        cycle(2'b01, 6'b000000, 1'b0, 1'b1, 4'd5, "mr_str_go");
        // Stalled load in MEMREAD
        cycle(2'b01, 6'b000001, 1'b0, 1'b1, 4'd0, "mr_ldr");
        cycle(2'b01, 6'b000001, 1'b0, 1'b1, 4'd1, "mr_ldr");
        cycle(2'b01, 6'b000001, 1'b0, 1'b1, 4'd2, "mr_ldr");
        cycle(2'b01, 6'b000001, 1'b0, 1'b0, 4'd3, "mr_ldr_hold");
        cycle(2'b01, 6'b000001, 1'b0, 1'b1, 4'd3, "mr_ldr_go");
        cycle(2'b01, 6'b000001, 1'b0, 1'b1, 4'd4, "mr_ldr");
`endif

        cycle(2'b00, 6'b000000, 1'b0, 1'b1, 4'd0, "final_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Control FSM for a multicycle version of the ARM datapath. One shared memory port and one ALU are used across several cycles per instruction.
- Sequences fetch, decode, execute, memory and writeback.
- Drives datapath mux selects and write strobes each cycle.
- Conditional gating (CondEx) and ALU-control decode stay external; this block emits pre-condition strobes only.

Parameters:
- STATE_W, 4, width of state register and debug state port.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- funct  in  6  instr[25:20]: funct[5]=I (immediate), funct[0]=S/L
- ir_write  out  1  latch instruction register
- next_pc  out  1  PC update request (fetch increment)
- branch  out  1  branch PC-write request, gated externally by CondEx
- reg_w  out  1  register-write request, gated externally by CondEx
- mem_w  out  1  memory-write request, gated externally by CondEx
- adr_src  out  1  0=PC, 1=ALU result as memory address
- alu_src_a  out  1  0=RD1, 1=PC
- alu_src_b  out  2  00=RD2/shifted, 01=ExtImm, 10=constant 4
- alu_op  out  1  1=ALU decoder uses funct; 0=force ADD
- result_src  out  2  00=ALUOut, 01=Data, 10=ALU result direct
- imm_src  out  2  equals op, combinational
- reg_src  out  2  [1]=(op==01), [0]=(op==10), combinational
- undef  out  1  one-cycle pulse in DECODE when op==11
- state  out  STATE_W  current state, debug

Behaviour:
- Moore FSM. Outputs are a combinational function of the registered state, except imm_src and reg_src (function of op) and undef (state and op).
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Unlisted strobes are 0; unlisted selects are 0.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, alu_op=0, result_src=10, ir_write=1, next_pc=1 -> DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10. Next state:
  - op=00, funct[5]=0 -> EXECR
  - op=00, funct[5]=1 -> EXECI
  - op=01 -> MEMADR
  - op=10 -> BRANCH
  - op=11 -> FETCH, undef=1
- MEMADR: alu_src_b=01. funct[0]=1 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: adr_src=1 -> MEMWB.
- MEMWB: result_src=01, reg_w=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_w=1 -> FETCH.
- EXECR: alu_src_b=00, alu_op=1 -> ALUWB.
- EXECI: alu_src_b=01, alu_op=1 -> ALUWB.
- ALUWB: reg_w=1 -> FETCH.
- BRANCH: alu_src_b=01, result_src=10, branch=1 -> FETCH.
- Latency: LDR 5 cycles, STR 4, data-processing 4, branch 3, undefined 2.
- Reset: state<=FETCH on the clk edge with reset=1.
  - While reset=1, strobes ir_write, next_pc, branch, reg_w, mem_w and undef are forced 0.
  - Selects show FETCH values.
  - Reset mid-instruction abandons it; no strobe fires in that cycle.
- Illegal state codes 10-15: all strobes 0 -> FETCH next cycle.
- op and funct are sampled only in DECODE and MEMADR (IR is stable from DECODE onward).

Optional Feature:
MEM_READY_EN
- Defined: adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - ir_write and next_pc assert only in the FETCH cycle with mem_ready=1.
  - mem_w stays high throughout MEMWRITE.
  - Transition out of these states only when mem_ready=1.
- Undefined: port absent; behaviour identical to mem_ready tied 1.

Decomposition:
- Package arm_ctrl_pkg:
  - state enum/localparams and STATE_W
  - op codes OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10
  - alu_src_b codes and result_src codes
- One sub-module, ctrl_state_decode: combinational state -> selects/strobes. The top holds the state register, next-state logic, reset gating and the mem_ready hold.

Test Plan:
- LDR: reset 2 cycles, then op=01, funct=011001 -> states 0,1,2,3,4,0; reg_w=1 only in MEMWB with result_src=01; ir_write=1 only in cycle 1.
- STR, ADD reg: op=01, funct=011000 -> 0,1,2,5,0 with mem_w=1 in MEMWRITE, adr_src=1. Then op=00, funct=001000 -> 0,1,6,8,0 with alu_op=1, alu_src_b=00 in EXECR.
- ADD imm, branch: op=00, funct=101000 -> EXECI with alu_src_b=01. Then op=10 -> 0,1,9,0 with branch=1, imm_src=10, reg_src=01.
- Undefined op: op=11 in DECODE -> undef pulses 1 cycle, next state FETCH, no reg_w/mem_w.
- Reset mid-op: assert reset in MEMWRITE -> mem_w=0 that cycle, state=0 next cycle; all strobes 0 while reset held.
- MEM_READY_EN: mem_ready low 3 cycles in FETCH -> state stays 0, ir_write=0; mem_ready=1 -> ir_write=1 and next_pc=1 for exactly one cycle, then DECODE.
